// File: rtl/udp_tx_pkg.sv
// udp_tx_pkg: shared state encoding, UDP header constants and helpers
// for the multi-channel UDP transmit packetizer.
package udp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INGEST  = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DROP    = 3'd4
  } state_e;

  localparam int         UDP_HDR_BYTES = 8;
  localparam logic [7:0] UDP_TTL       = 8'd64;
  localparam logic [5:0] UDP_DSCP      = 6'd0;
  localparam logic [1:0] UDP_ECN       = 2'd0;

  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + 7'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/udp_tx_packetizer_if.sv
// udp_tx_packetizer_if: UDP header handshake and byte payload stream
// toward the UDP/IP stack core.
interface udp_tx_packetizer_if;
  logic        tx_udp_hdr_valid;
  logic        tx_udp_hdr_ready;
  logic [5:0]  tx_udp_ip_dscp;
  logic [1:0]  tx_udp_ip_ecn;
  logic [7:0]  tx_udp_ip_ttl;
  logic [31:0] tx_udp_ip_source_ip;
  logic [31:0] tx_udp_ip_dest_ip;
  logic [15:0] tx_udp_source_port;
  logic [15:0] tx_udp_dest_port;
  logic [15:0] tx_udp_length;
  logic [15:0] tx_udp_checksum;
  logic [7:0]  tx_udp_payload_axis_tdata;
  logic        tx_udp_payload_axis_tvalid;
  logic        tx_udp_payload_axis_tlast;
  logic        tx_udp_payload_axis_tuser;
  logic        tx_udp_payload_axis_tready;

  modport master (
    output tx_udp_hdr_valid, tx_udp_ip_dscp, tx_udp_ip_ecn,
    output tx_udp_ip_ttl, tx_udp_ip_source_ip, tx_udp_ip_dest_ip,
    output tx_udp_source_port, tx_udp_dest_port, tx_udp_length,
    output tx_udp_checksum, tx_udp_payload_axis_tdata,
    output tx_udp_payload_axis_tvalid, tx_udp_payload_axis_tlast,
    output tx_udp_payload_axis_tuser,
    input  tx_udp_hdr_ready, tx_udp_payload_axis_tready
  );

  modport slave (
    input  tx_udp_hdr_valid, tx_udp_ip_dscp, tx_udp_ip_ecn,
    input  tx_udp_ip_ttl, tx_udp_ip_source_ip, tx_udp_ip_dest_ip,
    input  tx_udp_source_port, tx_udp_dest_port, tx_udp_length,
    input  tx_udp_checksum, tx_udp_payload_axis_tdata,
    input  tx_udp_payload_axis_tvalid, tx_udp_payload_axis_tlast,
    input  tx_udp_payload_axis_tuser,
    output tx_udp_hdr_ready, tx_udp_payload_axis_tready
  );
endinterface

// File: rtl/udp_tx_pkt_ram.sv
// udp_tx_pkt_ram: simple dual-port packet store, registered read,
// contents not reset.
module udp_tx_pkt_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/udp_tx_packetizer.sv
// udp_tx_packetizer: round-robin multi-channel store-and-forward
// UDP transmit packetizer with oversize-packet dropping.
module udp_tx_packetizer
  import udp_tx_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CH_N   = 2,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CH_N*DATA_W-1:0]     s_data,
  input  logic [CH_N*(DATA_W/8)-1:0] s_keep,
  input  logic [CH_N-1:0]            s_valid,
  input  logic [CH_N-1:0]            s_last,
  output logic [CH_N-1:0]            s_ready,
  udp_tx_packetizer_if.master        tx,
  input  logic [31:0]                local_ip,
  input  logic [31:0]                dest_ip,
  input  logic [15:0]                local_port,
  input  logic [15:0]                dest_port_base,
  output logic                       drop_pulse,
  output logic [15:0]                drop_count,
  output logic                       busy
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int CH_W   = (CH_N > 1) ? $clog2(CH_N) : 1;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW     = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d, rr_q, rr_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]     bsel_q, bsel_d;
  logic [15:0]       byte_cnt_q, byte_cnt_d;
  logic [15:0]       out_cnt_q, out_cnt_d;
  logic [15:0]       len_q, len_d, dport_q, dport_d;
  logic [15:0]       sport_q, sport_d;
  logic [31:0]       sip_q, sip_d, dip_q, dip_d;
  logic              drop_pulse_q, drop_pulse_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic [DATA_W-1:0] in_data, rd_data, sh;
  logic [KEEP_W-1:0] in_keep;
  logic              in_valid, in_last;
  logic [CH_W-1:0]   pick;
  logic              pick_ok, drop_done, last_byte;
  logic              we, re;
  logic [AW-1:0]     raddr;
  logic [15:0]       add, cnt_nx;

  always_comb begin
    in_data  = s_data[int'(grant_q)*DATA_W +: DATA_W];
    in_keep  = s_keep[int'(grant_q)*KEEP_W +: KEEP_W];
    in_valid = s_valid[grant_q];
    in_last  = s_last[grant_q];
  end

  // search starts at the channel after the previous grant
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int i = 0; i < CH_N; i++) begin
      if (!pick_ok && s_valid[(int'(rr_q) + i) % CH_N]) begin
        pick    = CH_W'((int'(rr_q) + i) % CH_N);
        pick_ok = 1'b1;
      end
    end
  end

  assign last_byte = (out_cnt_q == byte_cnt_q - 16'd1);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_d         = rr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    bsel_d       = bsel_q;
    byte_cnt_d   = byte_cnt_q;
    out_cnt_d    = out_cnt_q;
    len_d        = len_q;
    dport_d      = dport_q;
    sport_d      = sport_q;
    sip_d        = sip_q;
    dip_d        = dip_q;
    drop_pulse_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    drop_done    = 1'b0;
    we           = 1'b0;
    re           = 1'b0;
    raddr        = rd_ptr_q + 1'b1;
    add          = in_last ? 16'(popcount(64'(in_keep)))
                           : 16'(KEEP_W);
    cnt_nx       = byte_cnt_q + add;
    unique case (state_q)
      ST_IDLE: if (pick_ok) begin
        grant_d    = pick;
        rr_d       = (pick == CH_W'(CH_N - 1)) ? '0 : pick + 1'b1;
        wr_ptr_d   = '0;
        byte_cnt_d = '0;
        state_d    = ST_INGEST;
      end
      ST_INGEST: if (in_valid) begin
        if (wr_ptr_q == (AW+1)'(DEPTH)) begin
          if (in_last) drop_done = 1'b1;
          else         state_d   = ST_DROP;
        end else begin
          we         = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          byte_cnt_d = cnt_nx;
          if (in_last && cnt_nx == 16'd0) begin
            drop_done = 1'b1;
          end else if (in_last) begin
            len_d   = cnt_nx + 16'(UDP_HDR_BYTES);
            dport_d = dest_port_base + 16'(grant_q);
            sport_d = local_port;
            sip_d   = local_ip;
            dip_d   = dest_ip;
            state_d = ST_HEADER;
          end
        end
      end
      // word 0 is fetched here so payload starts without a bubble
      ST_HEADER: begin
        re    = 1'b1;
        raddr = '0;
        if (tx.tx_udp_hdr_ready) begin
          rd_ptr_d  = '0;
          bsel_d    = '0;
          out_cnt_d = '0;
          state_d   = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: if (tx.tx_udp_payload_axis_tready) begin
        if (last_byte) begin
          state_d = ST_IDLE;
        end else begin
          out_cnt_d = out_cnt_q + 16'd1;
          if (bsel_q == BW'(KEEP_W - 1)) begin
            bsel_d   = '0;
            rd_ptr_d = rd_ptr_q + 1'b1;
            re       = 1'b1;
          end else begin
            bsel_d = bsel_q + 1'b1;
          end
        end
      end
      ST_DROP: if (in_valid && in_last) drop_done = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    if (drop_done) begin
      state_d      = ST_IDLE;
      drop_pulse_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      rr_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      bsel_q       <= '0;
      byte_cnt_q   <= '0;
      out_cnt_q    <= '0;
      len_q        <= '0;
      dport_q      <= '0;
      sport_q      <= '0;
      sip_q        <= '0;
      dip_q        <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_q         <= rr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      bsel_q       <= bsel_d;
      byte_cnt_q   <= byte_cnt_d;
      out_cnt_q    <= out_cnt_d;
      len_q        <= len_d;
      dport_q      <= dport_d;
      sport_q      <= sport_d;
      sip_q        <= sip_d;
      dip_q        <= dip_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  udp_tx_pkt_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (in_data),
    .re    (re),
    .raddr (raddr),
    .rdata (rd_data)
  );

  assign sh = rd_data << (8 * int'(bsel_q));

  assign s_ready = (state_q == ST_INGEST || state_q == ST_DROP)
                 ? (CH_N'(1) << grant_q) : '0;

  assign tx.tx_udp_hdr_valid    = (state_q == ST_HEADER);
  assign tx.tx_udp_ip_dscp      = UDP_DSCP;
  assign tx.tx_udp_ip_ecn       = UDP_ECN;
  assign tx.tx_udp_ip_ttl       = tx.tx_udp_hdr_valid ? UDP_TTL : 8'd0;
  assign tx.tx_udp_ip_source_ip = sip_q;
  assign tx.tx_udp_ip_dest_ip   = dip_q;
  assign tx.tx_udp_source_port  = sport_q;
  assign tx.tx_udp_dest_port    = dport_q;
  assign tx.tx_udp_length       = len_q;
  assign tx.tx_udp_checksum     = '0;

  assign tx.tx_udp_payload_axis_tvalid = (state_q == ST_PAYLOAD);
  assign tx.tx_udp_payload_axis_tdata  =
    tx.tx_udp_payload_axis_tvalid ? sh[DATA_W-1 -: 8] : 8'd0;
  assign tx.tx_udp_payload_axis_tlast  =
    tx.tx_udp_payload_axis_tvalid && last_byte;
  assign tx.tx_udp_payload_axis_tuser  = 1'b0;

  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_cnt_q;
  assign busy       = (state_q != ST_IDLE);
endmodule
